ima_adpcm_blk_ctrl: RTL and testbench



---
 rtl/ima_adpcm_blk_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ima_adpcm_blk_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ima_adpcm_blk_ctrl.sv
// IMA ADPCM block sequencer: feeds PCM samples to one encoder and emits
// 4-byte-header blocks of packed 4-bit codes through a one-entry byte register.
module ima_adpcm_blk_ctrl #(
  parameter int unsigned BLOCK_NIBBLES = 504,
  parameter int unsigned CNT_W         = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] sampIn,
  input  logic        sampValid,
  output logic        sampReady,
  output logic [15:0] encInSamp,
  output logic        encInValid,
  input  logic        encInReady,
  input  logic [3:0]  encOutPCM,
  input  logic        encOutValid,
  input  logic [15:0] encPredictSamp,
  input  logic [6:0]  encStepIndex,
  output logic [7:0]  byteOut,
  output logic        byteValid,
  input  logic        byteReady,
  output logic        byteSop,
  output logic        byteEop,
  output logic        busy,
  output logic [15:0] blkCount
);

  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(BLOCK_NIBBLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_ACCEPT, S_FEED, S_WAIT
  } state_t;

  state_t           state, state_n;
  logic [15:0]      hdr_pred;
  logic [6:0]       hdr_idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       lo_nib;

  logic       byte_free;
  logic       ld_byte, ld_sop, ld_eop;
  logic [7:0] ld_data;
  logic       take_hdr, take_samp, store_lo, cnt_inc, cnt_clr, blk_done;

  assign byte_free = !byteValid || byteReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    state_n   = state;
    sampReady = 1'b0;
    ld_byte   = 1'b0;
    ld_sop    = 1'b0;
    ld_eop    = 1'b0;
    ld_data   = 8'h00;
    take_hdr  = 1'b0;
    take_samp = 1'b0;
    store_lo  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    blk_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          take_hdr = 1'b1;
          state_n  = S_HDR0;
        end
      end
      S_HDR0: if (byte_free) begin
        ld_byte = 1'b1;
        ld_data = hdr_pred[7:0];
        ld_sop  = 1'b1;
        state_n = S_HDR1;
      end
      S_HDR1: if (byte_free) begin
        ld_byte = 1'b1;
        ld_data = hdr_pred[15:8];
        state_n = S_HDR2;
      end
      S_HDR2: if (byte_free) begin
        ld_byte = 1'b1;
        ld_data = {1'b0, hdr_idx};
        state_n = S_HDR3;
      end
      S_HDR3: if (byte_free) begin
        ld_byte = 1'b1;
        ld_data = 8'h00;
        state_n = S_ACCEPT;
      end
      S_ACCEPT: begin
        // A pair-completing sample must find the byte slot free so its byte can never overwrite.
        sampReady = encInReady && (!cnt[0] || byte_free);
        if (sampReady && sampValid) begin
          take_samp = 1'b1;
          state_n   = S_FEED;
        end
      end
      S_FEED: state_n = S_WAIT;
      S_WAIT: begin
        if (encOutValid) begin
          if (cnt[0]) begin
            ld_byte = 1'b1;
            ld_data = {encOutPCM, lo_nib};
            ld_eop  = (cnt == LAST_NIB);
          end else begin
            store_lo = 1'b1;
          end
          if (cnt == LAST_NIB) begin
            cnt_clr  = 1'b1;
            blk_done = 1'b1;
            state_n  = S_IDLE;
          end else begin
            cnt_inc = 1'b1;
            state_n = S_ACCEPT;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hdr_pred   <= 16'h0000;
      hdr_idx    <= 7'h00;
      cnt        <= '0;
      lo_nib     <= 4'h0;
      encInSamp  <= 16'h0000;
      encInValid <= 1'b0;
      busy       <= 1'b0;
      blkCount   <= 16'h0000;
      byteOut    <= 8'h00;
      byteValid  <= 1'b0;
      byteSop    <= 1'b0;
      byteEop    <= 1'b0;
    end else begin
      busy       <= (state_n != S_IDLE);
      encInValid <= (state_n == S_FEED);
      if (take_hdr) begin
        hdr_pred <= encPredictSamp;
        hdr_idx  <= encStepIndex;
      end
      if (take_samp) encInSamp <= sampIn;
      if (store_lo)  lo_nib    <= encOutPCM;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (blk_done) blkCount <= blkCount + 16'd1;
      if (ld_byte) begin
        byteOut   <= ld_data;
        byteSop   <= ld_sop;
        byteEop   <= ld_eop;
        byteValid <= 1'b1;
      end else if (byteReady) begin
        byteValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ima_adpcm_blk_ctrl.sv
// Bench for ima_adpcm_blk_ctrl: behavioural IMA encoder stub, random PCM and
// handshake timing, and a byte-stream reference built from whole blocks.
module tb_ima_adpcm_blk_ctrl;

  localparam int unsigned NIB     = 4;
  localparam int unsigned CW      = 3;
  localparam int          CYC_MAX = 20000;

  logic        clock = 1'b0;
  logic        reset, enable, sampValid, byteReady;
  logic [15:0] sampIn;
  logic        sampReady, encInValid, encInReady, encOutValid;
  logic [15:0] encInSamp, encPredictSamp;
  logic [3:0]  encOutPCM;
  logic [6:0]  encStepIndex;
  logic [7:0]  byteOut;
  logic        byteValid, byteSop, byteEop, busy;
  logic [15:0] blkCount;

  always #5 clock = ~clock;

  ima_adpcm_blk_ctrl #(.BLOCK_NIBBLES(NIB), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .sampIn(sampIn), .sampValid(sampValid), .sampReady(sampReady),
    .encInSamp(encInSamp), .encInValid(encInValid), .encInReady(encInReady),
    .encOutPCM(encOutPCM), .encOutValid(encOutValid),
    .encPredictSamp(encPredictSamp), .encStepIndex(encStepIndex),
    .byteOut(byteOut), .byteValid(byteValid), .byteReady(byteReady),
    .byteSop(byteSop), .byteEop(byteEop), .busy(busy), .blkCount(blkCount)
  );

  int step_tbl [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442,
    11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794,
    32767};
  int idx_adj [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  // One IMA ADPCM encode step on integer predictor/index state.
  function automatic logic [3:0] ima_encode(input int s, inout int pred, inout int idx);
    int step, diff, vp;
    logic [3:0] code;
    step = step_tbl[idx];
    diff = s - pred;
    code = 4'h0;
    if (diff < 0) begin code[3] = 1'b1; diff = -diff; end
    vp = step / 8;
    if (diff >= step) begin code[2] = 1'b1; diff -= step; vp += step; end
    step = step / 2;
    if (diff >= step) begin code[1] = 1'b1; diff -= step; vp += step; end
    step = step / 2;
    if (diff >= step) begin code[0] = 1'b1; vp += step; end
    pred = code[3] ? pred - vp : pred + vp;
    if (pred > 32767)  pred = 32767;
    if (pred < -32768) pred = -32768;
    idx = idx + idx_adj[code[2:0]];
    if (idx < 0)  idx = 0;
    if (idx > 88) idx = 88;
    return code;
  endfunction

  // Encoder stub: one sample in flight, state updates with encOutValid.
  logic       enc_busy;
  int         enc_lat, st_pred, st_idx, pend_pred, pend_idx, tmp_pred, tmp_idx;
  logic [3:0] pend_code, tmp_code;

  assign encInReady     = !enc_busy;
  assign encPredictSamp = 16'(st_pred);
  assign encStepIndex   = 7'(st_idx);

  always_comb begin
    tmp_pred = st_pred;
    tmp_idx  = st_idx;
    tmp_code = ima_encode(int'($signed(encInSamp)), tmp_pred, tmp_idx);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      enc_busy    <= 1'b0;
      enc_lat     <= 0;
      encOutValid <= 1'b0;
      encOutPCM   <= 4'h0;
      st_pred     <= 0;
      st_idx      <= 0;
      pend_pred   <= 0;
      pend_idx    <= 0;
      pend_code   <= 4'h0;
    end else begin
      encOutValid <= 1'b0;
      if (enc_busy) begin
        if (enc_lat == 0) begin
          encOutValid <= 1'b1;
          encOutPCM   <= pend_code;
          st_pred     <= pend_pred;
          st_idx      <= pend_idx;
          enc_busy    <= 1'b0;
        end else begin
          enc_lat <= enc_lat - 1;
        end
      end else if (encInValid) begin
        pend_code <= tmp_code;
        pend_pred <= tmp_pred;
        pend_idx  <= tmp_idx;
        enc_busy  <= 1'b1;
        enc_lat   <= 4 + int'($urandom_range(0, 2));
      end
    end
  end

  typedef struct packed {
    logic [7:0] b;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t exp_q[$];
  int   smp[$];
  int   ref_pred, ref_idx, blk_exp;
  int   n_chk = 0, n_err = 0;
  bit   first_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected bytes of one block (possibly truncated to cnt samples).
  task automatic build_block(input int first, input int cnt);
    logic [15:0] p;
    logic [3:0]  c, lo;
    p  = 16'(ref_pred);
    lo = 4'h0;
    exp_q.push_back('{b: p[7:0],  sop: 1'b1, eop: 1'b0});
    exp_q.push_back('{b: p[15:8], sop: 1'b0, eop: 1'b0});
    exp_q.push_back('{b: {1'b0, 7'(ref_idx)}, sop: 1'b0, eop: 1'b0});
    exp_q.push_back('{b: 8'h00,   sop: 1'b0, eop: 1'b0});
    for (int i = 0; i < cnt; i++) begin
      c = ima_encode(smp[first + i], ref_pred, ref_idx);
      if (i % 2 == 0) lo = c;
      else exp_q.push_back('{b: {c, lo}, sop: 1'b0, eop: (i == int'(NIB) - 1)});
    end
  endtask

  task automatic push_rand(input int n);
    logic [15:0] r;
    for (int i = 0; i < n; i++) begin
      r = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000) - 1000);
      smp.push_back(int'($signed(r)));
    end
  endtask

  // Drive nblk blocks (last one cnt_last samples) with random timing; enable drops inside the last block.
  task automatic run_seq(input int nblk, input int cnt_last, input bit hold);
    int   total, sent, cyc, hold_left, nbyte;
    exp_t e;
    total = (nblk - 1) * int'(NIB) + cnt_last;
    exp_q.delete();
    for (int b = 0; b < nblk; b++) build_block(b * int'(NIB), (b == nblk - 1) ? cnt_last : int'(NIB));
    sent = 0; cyc = 0; nbyte = 0;
    hold_left = hold ? 8 : 0;
    while (!(sent == total && exp_q.size() == 0) && cyc < CYC_MAX) begin
      @(negedge clock);
      cyc++;
      enable    = (sent <= (nblk - 1) * int'(NIB));
      sampValid = (sent < total) && ($urandom_range(0, 3) != 0);
      sampIn    = (sent < total) ? 16'(smp[sent]) : 16'h0000;
      byteReady = (hold_left > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      #1;
      if (hold_left > 0 && byteValid) begin
        chk("hold_byte", byteOut, exp_q[0].b);
        chk("hold_sop", byteSop, 1);
        chk("hold_samp_ready", sampReady, 0);
        chk("hold_enc_valid", encInValid, 0);
        hold_left--;
      end
      if (byteValid && byteReady) begin
        if (exp_q.size() == 0) chk("extra_byte", byteValid, 0);
        else begin
          e = exp_q.pop_front();
          chk("byte", byteOut, e.b);
          chk("sop", byteSop, e.sop);
          chk("eop", byteEop, e.eop);
          if (first_run && nbyte == 4) chk("first_data", byteOut, 8'h70);
          nbyte++;
        end
      end
      if (sampValid && sampReady) sent++;
      if (encInValid) chk("enc_in_overlap", enc_busy, 0);
    end
    if (cyc >= CYC_MAX) chk("timeout_left", 32'(exp_q.size() + (total - sent)), 0);
    enable    = 1'b0;
    sampValid = 1'b0;
    byteReady = 1'b1;
  endtask

  task automatic idle_check(input int nblk);
    blk_exp += nblk;
    repeat (20) @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_byte_valid", byteValid, 0);
    chk("blk_count", blkCount, 16'(blk_exp));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_byte_valid"}, byteValid, 0);
    chk({tag, "_byte_out"}, byteOut, 0);
    chk({tag, "_sop_eop"}, {byteSop, byteEop}, 0);
    chk({tag, "_samp_ready"}, sampReady, 0);
    chk({tag, "_enc_valid"}, encInValid, 0);
    chk({tag, "_enc_samp"}, encInSamp, 0);
    chk({tag, "_blk_count"}, blkCount, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sampValid = 1'b0; sampIn = 16'h0000; byteReady = 1'b0;
    ref_pred = 0; ref_idx = 0; blk_exp = 0;
    repeat (3) @(negedge clock);
    #1 check_zero("reset");
    @(negedge clock) reset = 1'b0;

    // Directed first pair 0x0000, 0x03E8, with the first header byte stalled.
    smp.delete();
    smp.push_back(0);
    smp.push_back(1000);
    push_rand(3 * int'(NIB) - 2);
    first_run = 1'b1;
    run_seq(3, NIB, 1'b1);
    first_run = 1'b0;
    idle_check(3);

    smp.delete();
    push_rand(20 * int'(NIB));
    run_seq(20, NIB, 1'b0);
    idle_check(20);

    // Abort mid-block after three nibbles.
    smp.delete();
    push_rand(3);
    run_seq(1, 3, 1'b0);
    repeat (12) @(negedge clock);
    reset = 1'b1;
    #1 check_zero("abort");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ref_pred = 0; ref_idx = 0; blk_exp = 0;

    smp.delete();
    push_rand(2 * int'(NIB));
    run_seq(2, NIB, 1'b0);
    idle_check(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
